// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush scheduler.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int PERF_W_DEFAULT  = 32;

  // True when a source operand is actually read and names the given destination.
  function automatic logic reg_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the datapath and pipeline_ctrl; master is the scheduler side.
interface pipeline_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        rs1_ID;
  logic [4:0]        rs2_ID;
  logic              uses_rs1_ID;
  logic              uses_rs2_ID;
  logic              mem_read_EX;
  logic [4:0]        RD_EX;
  logic              mem_read_MEM;
  logic              mem_write_MEM;
  logic              Branch_MEM;
  logic              ZERO_MEM;
  logic              dmem_ready;
  logic              dmem_req;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              ex_mem_write;
  logic              mem_wb_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              mem_wb_flush;
  logic              pc_src;
  logic              dmem_err;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_events;

  modport master (
    input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, mem_read_EX, RD_EX,
           mem_read_MEM, mem_write_MEM, Branch_MEM, ZERO_MEM, dmem_ready,
    output dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_src, dmem_err,
           stall_cycles, flush_events
  );

  modport slave (
    output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, mem_read_EX, RD_EX,
           mem_read_MEM, mem_write_MEM, Branch_MEM, ZERO_MEM, dmem_ready,
    input  dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_src, dmem_err,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Purely combinational load-use detection between the load in EX and the consumer in ID.
module pipe_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       uses_rs1_ID,
  input  logic       uses_rs2_ID,
  input  logic       mem_read_EX,
  input  logic [4:0] RD_EX,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_read_EX && (RD_EX != 5'd0) &&
                    (reg_match(uses_rs1_ID, rs1_ID, RD_EX) ||
                     reg_match(uses_rs2_ID, rs2_ID, RD_EX));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: memory wait states, load-use and MEM branches.
// Optional performance counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int PERF_W  = PERF_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pipeline_ctrl_if.master         ctrl
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  ctrl_state_e      state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             dmem_err_q;

  logic mem_acc, timeout_hit, mem_stall, branch_taken, load_use;
  logic dmem_req_c, pc_write_c, if_id_write_c, id_ex_write_c, ex_mem_write_c, mem_wb_write_c;
  logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, mem_wb_flush_c, pc_src_c;

  pipe_hazard_detect u_hazard (
    .rs1_ID      (ctrl.rs1_ID),
    .rs2_ID      (ctrl.rs2_ID),
    .uses_rs1_ID (ctrl.uses_rs1_ID),
    .uses_rs2_ID (ctrl.uses_rs2_ID),
    .mem_read_EX (ctrl.mem_read_EX),
    .RD_EX       (ctrl.RD_EX),
    .load_use    (load_use)
  );

  assign mem_acc      = ctrl.mem_read_MEM | ctrl.mem_write_MEM;
  assign timeout_hit  = (state == MEM_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign mem_stall    = mem_acc & ~ctrl.dmem_ready & ~timeout_hit;
  assign branch_taken = ctrl.Branch_MEM & ctrl.ZERO_MEM;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      dmem_err_q <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      dmem_err_q <= dmem_err_q | timeout_hit;
    end
  end

  // Priority: memory stall freezes everything, then a taken branch wins over load-use.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    dmem_req_c     = 1'b0;
    pc_write_c     = 1'b0;
    if_id_write_c  = 1'b0;
    id_ex_write_c  = 1'b0;
    ex_mem_write_c = 1'b0;
    mem_wb_write_c = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    pc_src_c       = 1'b0;
    if (reset_n) begin
      dmem_req_c = mem_acc;
      if (mem_stall) begin
        mem_wb_flush_c = 1'b1;
        state_next     = MEM_WAIT;
        wait_cnt_next  = wait_cnt + 1'b1;
      end else begin
        state_next     = RUN;
        wait_cnt_next  = '0;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        id_ex_write_c  = 1'b1;
        ex_mem_write_c = 1'b1;
        mem_wb_write_c = 1'b1;
        if (branch_taken) begin
          pc_src_c       = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_flush_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
        end else if (load_use) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_flush_c = 1'b1;
        end
      end
    end
  end

  assign ctrl.dmem_req     = dmem_req_c;
  assign ctrl.pc_write     = pc_write_c;
  assign ctrl.if_id_write  = if_id_write_c;
  assign ctrl.id_ex_write  = id_ex_write_c;
  assign ctrl.ex_mem_write = ex_mem_write_c;
  assign ctrl.mem_wb_write = mem_wb_write_c;
  assign ctrl.if_id_flush  = if_id_flush_c;
  assign ctrl.id_ex_flush  = id_ex_flush_c;
  assign ctrl.ex_mem_flush = ex_mem_flush_c;
  assign ctrl.mem_wb_flush = mem_wb_flush_c;
  assign ctrl.pc_src       = pc_src_c;
  assign ctrl.dmem_err     = dmem_err_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((!pc_write_c || mem_stall) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (pc_src_c && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign ctrl.stall_cycles = stall_cnt;
  assign ctrl.flush_events = flush_cnt;
`else
  assign ctrl.stall_cycles = '0;
  assign ctrl.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with hand-computed control vectors.
module tb_pipeline_ctrl;

  // Vector layout: {dmem_req, pc/if_id/id_ex/ex_mem/mem_wb write, if_id/id_ex/ex_mem/mem_wb flush, pc_src, dmem_err}
  localparam logic [11:0] V_RESET    = 12'b0_00000_0000_0_0;
  localparam logic [11:0] V_NORM     = 12'b0_11111_0000_0_0;
  localparam logic [11:0] V_NORM_ERR = 12'b0_11111_0000_0_1;
  localparam logic [11:0] V_LU       = 12'b0_00111_0100_0_0;
  localparam logic [11:0] V_BR       = 12'b0_11111_1110_1_0;
  localparam logic [11:0] V_STALL    = 12'b1_00000_0001_0_0;
  localparam logic [11:0] V_MEMGO    = 12'b1_11111_0000_0_0;
  localparam logic [11:0] V_MEMGO_BR = 12'b1_11111_1110_1_0;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] outv;
  logic [31:0] exp_stall, exp_flush;

  pipeline_ctrl_if #(.PERF_W(32)) bus ();

  pipeline_ctrl #(.TIMEOUT(16), .PERF_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (bus)
  );

  always #5 clk = ~clk;

  assign outv = {bus.dmem_req, bus.pc_write, bus.if_id_write, bus.id_ex_write,
                 bus.ex_mem_write, bus.mem_wb_write, bus.if_id_flush, bus.id_ex_flush,
                 bus.ex_mem_flush, bus.mem_wb_flush, bus.pc_src, bus.dmem_err};

  task automatic clear_inputs();
    bus.rs1_ID        = 5'd0;
    bus.rs2_ID        = 5'd0;
    bus.uses_rs1_ID   = 1'b0;
    bus.uses_rs2_ID   = 1'b0;
    bus.mem_read_EX   = 1'b0;
    bus.RD_EX         = 5'd0;
    bus.mem_read_MEM  = 1'b0;
    bus.mem_write_MEM = 1'b0;
    bus.Branch_MEM    = 1'b0;
    bus.ZERO_MEM      = 1'b0;
    bus.dmem_ready    = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [11:0] exp);
    checks++;
    assert (outv === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s got %b exp %b", tag, outv, exp);
    end
  endtask

  task automatic check_counter(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Inputs are set at a falling edge; check settles 1 ns later, then one full clock passes.
  task automatic apply_stimulus(input string tag, input logic [11:0] exp);
    #1;
    check_output(tag, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_timeout(input string tag);
    bus.mem_read_MEM = 1'b1;
    bus.dmem_ready   = 1'b0;
    for (int i = 0; i < 15; i++) apply_stimulus({tag, "_stall"}, V_STALL);
    apply_stimulus({tag, "_release"}, V_MEMGO);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    bus.mem_read_MEM = 1'b1;
    bus.Branch_MEM   = 1'b1;
    bus.ZERO_MEM     = 1'b1;
    #1;
    check_output("reset_outputs", V_RESET);
    check_counter("reset_stall_cnt", bus.stall_cycles, 32'd0);
    check_counter("reset_flush_cnt", bus.flush_events, 32'd0);

    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    apply_stimulus("idle_normal", V_NORM);

    bus.mem_read_EX = 1'b1; bus.RD_EX = 5'd5; bus.uses_rs1_ID = 1'b1; bus.rs1_ID = 5'd5;
    apply_stimulus("loaduse_rs1", V_LU);
    clear_inputs();
    apply_stimulus("after_loaduse", V_NORM);

    bus.mem_read_EX = 1'b1; bus.RD_EX = 5'd7; bus.uses_rs2_ID = 1'b1; bus.rs2_ID = 5'd7;
    apply_stimulus("loaduse_rs2", V_LU);
    clear_inputs();

    bus.mem_read_EX = 1'b1; bus.RD_EX = 5'd0; bus.uses_rs1_ID = 1'b1; bus.rs1_ID = 5'd0;
    apply_stimulus("load_x0_nostall", V_NORM);
    clear_inputs();

    bus.mem_read_EX = 1'b1; bus.RD_EX = 5'd9; bus.uses_rs1_ID = 1'b0; bus.rs1_ID = 5'd9;
    apply_stimulus("unused_rs1_nostall", V_NORM);
    clear_inputs();

    bus.Branch_MEM = 1'b1; bus.ZERO_MEM = 1'b1;
    bus.mem_read_EX = 1'b1; bus.RD_EX = 5'd5; bus.uses_rs1_ID = 1'b1; bus.rs1_ID = 5'd5;
    apply_stimulus("branch_over_loaduse", V_BR);
    clear_inputs();

    bus.Branch_MEM = 1'b1; bus.ZERO_MEM = 1'b0;
    apply_stimulus("branch_not_taken", V_NORM);
    clear_inputs();

    bus.mem_read_MEM = 1'b1; bus.dmem_ready = 1'b1;
    apply_stimulus("mem_zero_wait", V_MEMGO);
    clear_inputs();

    // Store with three wait states, carrying a taken branch frozen behind it.
    bus.mem_write_MEM = 1'b1; bus.Branch_MEM = 1'b1; bus.ZERO_MEM = 1'b1;
    apply_stimulus("store_wait1", V_STALL);
    apply_stimulus("store_wait2", V_STALL);
    apply_stimulus("store_wait3", V_STALL);
    bus.dmem_ready = 1'b1;
    apply_stimulus("store_ready_branch", V_MEMGO_BR);
    clear_inputs();
    apply_stimulus("after_store_no_err", V_NORM);

    run_timeout("timeout1");
    apply_stimulus("err_set", V_NORM_ERR);
    apply_stimulus("err_sticky", V_NORM_ERR);

`ifdef PIPELINE_CTRL_PERF_EN
    exp_stall = 32'd20;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    check_counter("stall_cycles", bus.stall_cycles, exp_stall);
    check_counter("flush_events", bus.flush_events, exp_flush);

    // Drop reset while the FSM sits in MEM_WAIT.
    bus.mem_read_MEM = 1'b1;
    apply_stimulus("pre_reset_stall_run", V_STALL_ERR());
    apply_stimulus("pre_reset_stall_wait", V_STALL_ERR());
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset_outputs", V_RESET);
    check_counter("async_reset_stall_cnt", bus.stall_cycles, 32'd0);
    check_counter("async_reset_flush_cnt", bus.flush_events, 32'd0);
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    apply_stimulus("post_reset_normal", V_NORM);

    run_timeout("timeout2");
    apply_stimulus("err_set_again", V_NORM_ERR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // dmem_err is already set from the first timeout when these stalls happen.
  function automatic logic [11:0] V_STALL_ERR();
    return V_STALL | 12'b0_00000_0000_0_1;
  endfunction

endmodule
